control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Generates the one-hot machine-cycle state (fetch/exec1/exec2) consumed by the instruction decoder and owns the 4-bit instruction register. It sequences each instruction through one or two execute cycles depending on opcode, enters a sticky halt on STP, and supports free-run and single-step operation. It sits between the program memory output and the decoder in the Harvard CPU top level.

Parameters:
ICNT_W, 16, width of the retired-instruction counter
EXEC2_MASK, 16'h0024, bit n set means opcode n needs exec2; default covers ADD (2) and LDA (5)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = execute instructions, 0 = pause at next instruction boundary
single_step  input  1  level; 1 = step mode, one instruction per step pulse
step  input  1  step request, rising-edge detected internally
inst_in  input  4  opcode from program memory, valid during fetch
state  output  3  one-hot: [0]=fetch, [1]=exec1, [2]=exec2; 3'b000 when idle or halted
inst  output  4  instruction register, drives the decoder
ir_load  output  1  high in the fetch cycle, when IR captures inst_in at the next edge
halted  output  1  sticky; set after STP completes
busy  output  1  high whenever state != 3'b000
icount  output  ICNT_W  retired-instruction count

Behaviour:
- FSM states: IDLE, FETCH, EXEC1, EXEC2, HALT. state output is encoded IDLE=000, FETCH=001, EXEC1=010, EXEC2=100, HALT=000. halted=1 only in HALT.
- Reset (async, rst_n=0): FSM=IDLE, state=000, inst=4'h0, halted=0, icount=0, step edge register=0. Reset asserted mid-instruction aborts the instruction immediately with no partial effects.
- go = run & (~single_step | step_rise). step_rise = step & ~step_q, where step_q is registered step.
- IDLE: if go, next state is FETCH. Otherwise remain in IDLE.
- FETCH: ir_load=1; IR <= inst_in at the edge; next state is always EXEC1. The decode for the next transition uses the newly loaded IR.
- EXEC1:
  - If inst==4'b0100 (STP), next state is HALT. STP counts as retired (icount+1).
  - Else if EXEC2_MASK[inst]==1, next state is EXEC2.
  - Else the instruction retires (icount+1). Next state is FETCH if go_cont, else IDLE.
  - Opcodes with inst[3]=1 (ARM class) are single-exec unless their mask bit is set.
- EXEC2: the instruction retires (icount+1). Next state is FETCH if go_cont, else IDLE.
- go_cont = run & ~single_step. In step mode, exactly one instruction executes per step_rise, then the FSM returns to IDLE.
- run deasserted mid-instruction: the current instruction completes through its last exec cycle, then the FSM goes to IDLE. No cycle is truncated.
- step_rise while not in IDLE is ignored; it is not queued.
- Switching single_step mid-instruction takes effect at the next retirement boundary.
- HALT: sticky. run and step are ignored. Only rst_n exits HALT. IR holds the STP opcode.
- icount wraps modulo 2^ICNT_W with no saturation.
- All outputs are registered or decoded directly from FSM/IR flops, with no combinational path from inputs. The exception is ir_load, which is decoded from FSM state only.
- Instruction latency: 2 cycles (FETCH+EXEC1), or 3 cycles for EXEC2_MASK opcodes. Back-to-back free-run has no IDLE bubble between instructions.

Test Plan:
- Reset, run=1, single_step=0, program LDI(0), ADD(2), JMP(3) -> state sequence 001,010,001,010,100,001,010. icount=1, 2, 3 at the respective retirement edges. No 000 between instructions.
- Program LDA(5) then STP(4) -> 001,010,100,001,010, then 000 forever. halted=1, icount=2, inst=4'h4. Toggling run and step afterward causes no change.
- single_step=1, run=1, three step pulses spaced 10 cycles apart over LDI, ADD, STA -> each pulse yields exactly one instruction (2, 3, 2 busy cycles). The FSM is in IDLE between pulses. Holding step high for 5 cycles counts as one step.
- run dropped during EXEC1 of ADD -> EXEC2 still occurs, icount increments, then IDLE. Raising run again resumes at FETCH.
- rst_n pulsed low during EXEC2 of LDA -> state=000, inst=0, icount=0, halted=0 immediately, without waiting for a clock edge.
- ICNT_W=4, run 17 single-exec instructions -> icount wraps 15 to 0 and reads 1 at the end.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Machine-cycle sequencer for the Harvard CPU. Produces the one-hot cycle
//   state (fetch/exec1/exec2) consumed by the instruction decoder, owns the
//   4-bit instruction register, counts retired instructions, and enters a
//   sticky halt on STP. Supports free-run and single-step operation.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   run          level: execute instructions / pause at next boundary
//   single_step  level: one instruction per rising edge of step
//   step         step request (rising edge detected internally)
//   inst_in      opcode from program memory, sampled during fetch
//   state        one-hot {exec2, exec1, fetch}; 000 when idle or halted
//   inst         instruction register, drives the decoder
//   ir_load      fetch cycle marker; IR captures inst_in at the next edge
//   halted       sticky halt flag, set after STP retires
//   busy         high whenever state != 000
//   icount       retired-instruction count, wraps modulo 2^ICNT_W
module control_sequencer #(
  parameter int unsigned ICNT_W     = 16,
  parameter logic [15:0] EXEC2_MASK = 16'h0024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              single_step,
  input  logic              step,
  input  logic [3:0]        inst_in,
  output logic [2:0]        state,
  output logic [3:0]        inst,
  output logic              ir_load,
  output logic              halted,
  output logic              busy,
  output logic [ICNT_W-1:0] icount
);

  localparam logic [3:0] OP_STP = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [3:0]        inst_q, inst_d;
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic              step_q, step_d;

  logic              step_rise;
  logic              go;
  logic              go_cont;
  logic              retire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      inst_q   <= '0;
      icount_q <= '0;
      step_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      inst_q   <= inst_d;
      icount_q <= icount_d;
      step_q   <= step_d;
    end
  end

  // Next-state logic
  always_comb begin
    step_rise = step & ~step_q;
    go        = run & (~single_step | step_rise);
    go_cont   = run & ~single_step;
    fsm_d     = fsm_q;
    retire    = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (go) fsm_d = S_FETCH;
      end
      S_FETCH: begin
        fsm_d = S_EXEC1;
      end
      S_EXEC1: begin
        // STP is checked ahead of the mask so a mask bit on opcode 4 cannot
        // stretch the halting instruction.
        if (inst_q == OP_STP) begin
          fsm_d  = S_HALT;
          retire = 1'b1;
        end else if (EXEC2_MASK[inst_q]) begin
          fsm_d = S_EXEC2;
        end else begin
          retire = 1'b1;
          fsm_d  = go_cont ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC2: begin
        retire = 1'b1;
        fsm_d  = go_cont ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        fsm_d = S_HALT;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    step_d   = step;
    inst_d   = (fsm_q == S_FETCH) ? inst_in : inst_q;
    icount_d = retire ? (icount_q + ICNT_W'(1)) : icount_q;
  end

  // Outputs, decoded from flops only
  always_comb begin
    state = 3'b000;
    case (fsm_q)
      S_FETCH: state = 3'b001;
      S_EXEC1: state = 3'b010;
      S_EXEC2: state = 3'b100;
      default: state = 3'b000;
    endcase
    ir_load = (fsm_q == S_FETCH);
    halted  = (fsm_q == S_HALT);
    busy    = (state != 3'b000);
    inst    = inst_q;
    icount  = icount_q;
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        single_step;
  logic        step;
  logic [3:0]  inst_in;

  logic [2:0]  state;
  logic [3:0]  inst;
  logic        ir_load;
  logic        halted;
  logic        busy;
  logic [15:0] icount;

  logic [2:0]  state4;
  logic [3:0]  inst4;
  logic        ir_load4;
  logic        halted4;
  logic        busy4;
  logic [3:0]  icount4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .single_step(single_step),
    .step(step), .inst_in(inst_in), .state(state), .inst(inst),
    .ir_load(ir_load), .halted(halted), .busy(busy), .icount(icount)
  );

  control_sequencer #(.ICNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .single_step(single_step),
    .step(step), .inst_in(inst_in), .state(state4), .inst(inst4),
    .ir_load(ir_load4), .halted(halted4), .busy(busy4), .icount(icount4)
  );

  // One expected cycle: stimulus applied before an edge, and what the
  // outputs must show after that edge.
  typedef struct packed {
    logic        r;
    logic        ss;
    logic        sp;
    logic [3:0]  din;
    logic [2:0]  st;
    logic [3:0]  ir;
    logic [31:0] ic;
    logic        hlt;
  } cyc_t;

  cyc_t        q[$];
  int unsigned m_ic;
  logic [3:0]  m_inst;

  // Reference: opcodes needing a second execute cycle are ADD and LDA.
  function automatic bit two_exec(logic [3:0] op);
    return (op == 4'd2) || (op == 4'd5);
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] o;
    do o = 4'($urandom_range(0, 15)); while (o == 4'd4);
    return o;
  endfunction

  task automatic push(logic r, logic ss, logic sp, logic [3:0] din,
                      logic [2:0] st, logic [3:0] ir, int unsigned ic, logic hlt);
    cyc_t e;
    e.r = r; e.ss = ss; e.sp = sp; e.din = din;
    e.st = st; e.ir = ir; e.ic = ic; e.hlt = hlt;
    q.push_back(e);
  endtask

  // Free-run instruction: fetch, exec1, optional exec2. rl is the run level
  // held from exec1 onward; the entry after the last exec decides FETCH/IDLE.
  task automatic add_instr(logic [3:0] op, logic rl);
    push(1'b1, 1'b0, 1'b0, 4'h0, 3'b001, m_inst, m_ic, 1'b0);
    m_inst = op;
    push(1'b1, 1'b0, 1'b0, op, 3'b010, op, m_ic, 1'b0);
    if (op == 4'd4) begin
      m_ic++;
      push(1'b1, 1'b0, 1'b0, 4'h0, 3'b000, op, m_ic, 1'b1);
    end else begin
      if (two_exec(op)) push(rl, 1'b0, 1'b0, 4'h0, 3'b100, op, m_ic, 1'b0);
      m_ic++;
    end
  endtask

  task automatic add_idle(int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      push(1'b0, 1'b0, 1'b0, 4'h0, 3'b000, m_inst, m_ic, 1'b0);
  endtask

  // Ten-cycle step window: step high for h cycles, optional second rise while
  // the instruction is still executing (must be ignored).
  task automatic add_step_window(logic [3:0] op, int unsigned h, bit glitch);
    int unsigned len;
    len = two_exec(op) ? 3 : 2;
    for (int unsigned k = 0; k < 10; k++) begin
      logic       sp;
      logic [2:0] st;
      logic [3:0] ir;
      int unsigned ic;
      sp = (k < h) || (glitch && k == 2);
      if (k == 0) begin
        st = 3'b001; ir = m_inst; ic = m_ic;
      end else if (k == 1) begin
        st = 3'b010; ir = op; ic = m_ic;
      end else if (k < len) begin
        st = 3'b100; ir = op; ic = m_ic;
      end else begin
        st = 3'b000; ir = op; ic = m_ic + 1;
      end
      push(1'b1, 1'b1, sp, (k == 1) ? op : 4'h0, st, ir, ic, 1'b0);
    end
    m_inst = op;
    m_ic++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; run = 1'b0; single_step = 1'b0; step = 1'b0; inst_in = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_ic   = 0;
    m_inst = 4'h0;
    q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL reset_state got=%b exp=000", state); end
    n_checks++; if (inst !== 4'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", inst); end
    n_checks++; if (icount !== 16'h0) begin n_fail++; $display("FAIL reset_icount got=%0d exp=0", icount); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_checks++; if (busy !== 1'b0 || ir_load !== 1'b0) begin n_fail++; $display("FAIL reset_busy_irload got=%b%b exp=00", busy, ir_load); end
    // Stay idle with run low, and in step mode with no step edge.
    for (int i = 0; i < 4; i++) begin
      run = (i >= 2); single_step = (i >= 2); step = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL idle_hold cyc=%0d got=%b exp=000", i, state); end
    end
  endtask

  task automatic test_free_run();
    cyc_t e;
    int unsigned n;
    int cyc;
    logic [3:0] op;
    apply_reset();
    n = $urandom_range(17, 22);
    for (int unsigned i = 0; i < n; i++) begin
      if (i == 0) op = 4'd0;
      else if (i == 1) op = 4'd2;
      else if (i == 2) op = 4'd3;
      else if (i == n - 1) op = 4'd2;
      else op = rand_op();
      add_instr(op, i != n - 1);
    end
    add_idle(3);
    for (int unsigned i = 0; i < 3; i++) add_instr(rand_op(), i != 2);
    add_idle(2);
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      run = e.r; single_step = e.ss; step = e.sp; inst_in = e.din;
      @(posedge clk); #1;
      n_checks++; if (state !== e.st) begin n_fail++; $display("FAIL fr_state cyc=%0d got=%b exp=%b", cyc, state, e.st); end
      n_checks++; if (inst !== e.ir) begin n_fail++; $display("FAIL fr_inst cyc=%0d got=%h exp=%h", cyc, inst, e.ir); end
      n_checks++; if (icount !== e.ic[15:0]) begin n_fail++; $display("FAIL fr_icount cyc=%0d got=%0d exp=%0d", cyc, icount, e.ic[15:0]); end
      n_checks++; if (icount4 !== e.ic[3:0]) begin n_fail++; $display("FAIL fr_icount_wrap cyc=%0d got=%0d exp=%0d", cyc, icount4, e.ic[3:0]); end
      n_checks++; if (halted !== e.hlt) begin n_fail++; $display("FAIL fr_halted cyc=%0d got=%b exp=%b", cyc, halted, e.hlt); end
      n_checks++; if (busy !== (e.st != 3'b000)) begin n_fail++; $display("FAIL fr_busy cyc=%0d got=%b exp=%b", cyc, busy, e.st != 3'b000); end
      n_checks++; if (ir_load !== (e.st == 3'b001)) begin n_fail++; $display("FAIL fr_ir_load cyc=%0d got=%b exp=%b", cyc, ir_load, e.st == 3'b001); end
      cyc++;
    end
  endtask

  task automatic test_single_step();
    cyc_t e;
    int cyc;
    int unsigned h;
    logic [3:0] ops [6];
    apply_reset();
    ops[0] = 4'd0; ops[1] = 4'd2; ops[2] = 4'd6;
    for (int i = 3; i < 6; i++) ops[i] = rand_op();
    push(1'b1, 1'b1, 1'b0, 4'h0, 3'b000, 4'h0, 0, 1'b0);
    push(1'b1, 1'b1, 1'b0, 4'h0, 3'b000, 4'h0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      h = (i == 0) ? 5 : $urandom_range(1, 5);
      add_step_window(ops[i], h, (h == 1) && ($urandom_range(0, 1) == 1 || i == 2));
    end
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      run = e.r; single_step = e.ss; step = e.sp; inst_in = e.din;
      @(posedge clk); #1;
      n_checks++; if (state !== e.st) begin n_fail++; $display("FAIL ss_state cyc=%0d got=%b exp=%b", cyc, state, e.st); end
      n_checks++; if (inst !== e.ir) begin n_fail++; $display("FAIL ss_inst cyc=%0d got=%h exp=%h", cyc, inst, e.ir); end
      n_checks++; if (icount !== e.ic[15:0]) begin n_fail++; $display("FAIL ss_icount cyc=%0d got=%0d exp=%0d", cyc, icount, e.ic[15:0]); end
      n_checks++; if (busy !== (e.st != 3'b000)) begin n_fail++; $display("FAIL ss_busy cyc=%0d got=%b exp=%b", cyc, busy, e.st != 3'b000); end
      cyc++;
    end
  endtask

  task automatic test_halt();
    cyc_t e;
    int cyc;
    int unsigned n;
    apply_reset();
    add_instr(4'd5, 1'b1);
    n = $urandom_range(0, 3);
    for (int unsigned i = 0; i < n; i++) add_instr(rand_op(), 1'b1);
    add_instr(4'd4, 1'b1);
    for (int i = 0; i < 12; i++)
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 3'b000, 4'h4, m_ic, 1'b1);
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      run = e.r; single_step = e.ss; step = e.sp; inst_in = e.din;
      @(posedge clk); #1;
      n_checks++; if (state !== e.st) begin n_fail++; $display("FAIL halt_state cyc=%0d got=%b exp=%b", cyc, state, e.st); end
      n_checks++; if (inst !== e.ir) begin n_fail++; $display("FAIL halt_inst cyc=%0d got=%h exp=%h", cyc, inst, e.ir); end
      n_checks++; if (icount !== e.ic[15:0]) begin n_fail++; $display("FAIL halt_icount cyc=%0d got=%0d exp=%0d", cyc, icount, e.ic[15:0]); end
      n_checks++; if (halted !== e.hlt) begin n_fail++; $display("FAIL halt_flag cyc=%0d got=%b exp=%b", cyc, halted, e.hlt); end
      n_checks++; if (busy !== (e.st != 3'b000)) begin n_fail++; $display("FAIL halt_busy cyc=%0d got=%b exp=%b", cyc, busy, e.st != 3'b000); end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_exec2();
    apply_reset();
    run = 1'b1; single_step = 1'b0; step = 1'b0; inst_in = 4'h0;
    @(posedge clk); #1;             // FETCH LDI
    @(posedge clk); #1;             // EXEC1 LDI
    inst_in = 4'h5;
    @(posedge clk); #1;             // FETCH LDA
    @(posedge clk); #1;             // EXEC1 LDA
    inst_in = 4'h0;
    @(posedge clk); #1;             // EXEC2 LDA
    n_checks++; if (state !== 3'b100) begin n_fail++; $display("FAIL pre_rst_state got=%b exp=100", state); end
    n_checks++; if (icount !== 16'd1 || inst !== 4'h5) begin n_fail++; $display("FAIL pre_rst_regs got=%0d/%h exp=1/5", icount, inst); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL async_rst_state got=%b exp=000", state); end
    n_checks++; if (inst !== 4'h0) begin n_fail++; $display("FAIL async_rst_inst got=%h exp=0", inst); end
    n_checks++; if (icount !== 16'h0) begin n_fail++; $display("FAIL async_rst_icount got=%0d exp=0", icount); end
    n_checks++; if (halted !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags got=%b%b exp=00", halted, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (state !== 3'b001) begin n_fail++; $display("FAIL post_rst_restart got=%b exp=001", state); end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_step();
    test_halt();
    test_reset_mid_exec2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
